bus_router: RTL and testbench

- Parametrised successor of the core's data-side address decoder.
- Routes one master request port to N_SLAVES memory-mapped slaves, each described by a base/mask pair.
- Tracks one outstanding transaction and returns the selected slave's response, stalling the master meanwhile.
- Flags unmapped addresses, and optionally slave timeouts, as error responses.
- Sits between the LSU and the data RAM, LEDs, HEX and future peripherals.

---
 rtl/bus_router.sv | 135 +++++++++++++
 tb/tb_bus_router.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bus_router.sv
// ============================================================================
//  Module   : bus_router
//  Purpose  : Routes one master request port to N_SLAVES base/mask-decoded
//             slaves, tracking one outstanding transaction. Optional slave
//             timeout enabled by defining BUS_ROUTER_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_router #(
  parameter int                      N_SLAVES       = 4,
  parameter int                      SEL_WIDTH      = $clog2(N_SLAVES),
  parameter logic [32*N_SLAVES-1:0]  BASE_ADDRS     = {32'h80002000, 32'h80001000,
                                                       32'h80000800, 32'h00000000},
  parameter logic [32*N_SLAVES-1:0]  ADDR_MASKS     = {32'hFFFFF000, 32'hFFFFFFF0,
                                                       32'hFFFFFFFC, 32'hFFFFFF00},
  parameter int                      TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              wdata_i,
  input  logic [3:0]               be_i,
  output logic                     stall_o,
  output logic                     rsp_valid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  output logic [N_SLAVES-1:0]      req_o,
  output logic                     we_o,
  output logic [31:0]              addr_o,
  output logic [31:0]              wdata_o,
  output logic [3:0]               be_o,
  input  logic [N_SLAVES-1:0]      rsp_valid_i,
  input  logic [32*N_SLAVES-1:0]   rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t                r_state;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_we;

  logic                  w_hit;
  logic [SEL_WIDTH-1:0]  w_hit_idx;
  logic                  w_sel_rsp;
  logic                  w_timeout;
  logic                  w_accept;
  logic [31:0]           w_rdata [N_SLAVES];

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_rdata
    assign w_rdata[g] = rdata_i[32*g +: 32];
  end

  // Descending scan so that the lowest matching index is the last one written.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & ADDR_MASKS[32*i +: 32]) == BASE_ADDRS[32*i +: 32]) begin
        w_hit     = 1'b1;
        w_hit_idx = SEL_WIDTH'(i);
      end
    end
  end

  assign w_sel_rsp = (r_state == S_BUSY) && rsp_valid_i[r_sel];

`ifdef BUS_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = (r_state == S_BUSY) && !rsp_valid_i[r_sel] &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == S_BUSY) && (r_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  assign w_accept = req_i && !rst_i &&
                    ((r_state == S_IDLE) || (r_state == S_ERR) || w_sel_rsp || w_timeout);

  assign we_o    = we_i;
  assign addr_o  = addr_i;
  assign wdata_o = wdata_i;
  assign be_o    = be_i;

  // Outputs are forced low while reset is asserted, including a late response.
  assign stall_o     = req_i && !rst_i && !w_accept;
  assign req_o       = (w_accept && w_hit) ? (N_SLAVES'(1) << w_hit_idx) : '0;
  assign rsp_valid_o = !rst_i && (w_sel_rsp || (r_state == S_ERR) || w_timeout);
  assign err_o       = !rst_i && ((r_state == S_ERR) || w_timeout);
  assign rdata_o     = (!rst_i && w_sel_rsp && !r_we) ? w_rdata[r_sel] : 32'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_we    <= 1'b0;
    end else if (w_accept) begin
      r_we <= we_i;
      if (w_hit) begin
        r_sel   <= w_hit_idx;
        r_state <= S_BUSY;
      end else begin
        r_state <= S_ERR;
      end
    end else begin
      case (r_state)
        S_BUSY:  if (w_sel_rsp || w_timeout) r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_router.sv
// ============================================================================
//  Module   : tb_bus_router
//  Purpose  : Vector-table bench for bus_router plus multi-cycle sequences
//             (indefinite wait, or timeout when BUS_ROUTER_TIMEOUT_EN is set).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_router;

  logic         clk_i = 1'b0;
  logic         rst_i, req_i, we_i;
  logic [31:0]  addr_i, wdata_i;
  logic [3:0]   be_i;
  logic         stall_o, rsp_valid_o, err_o, we_o;
  logic [31:0]  rdata_o, addr_o, wdata_o;
  logic [3:0]   req_o, be_o, rsp_valid_i;
  logic [127:0] rdata_i;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  bus_router #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .stall_o(stall_o), .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o), .err_o(err_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .rsp_valid_i(rsp_valid_i), .rdata_i(rdata_i)
  );

  typedef struct {
    logic        rst, req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  rsp;
    logic [31:0] rd0;
    logic        e_stall, e_rv, e_err;
    logic [31:0] e_rdata;
    logic [3:0]  e_req;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic req, logic we, logic [31:0] addr,
                              logic [31:0] wdata, logic [3:0] rsp, logic [31:0] rd0,
                              logic e_stall, logic e_rv, logic e_err,
                              logic [31:0] e_rdata, logic [3:0] e_req);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
    v.rsp = rsp; v.rd0 = rd0; v.e_stall = e_stall; v.e_rv = e_rv;
    v.e_err = e_err; v.e_rdata = e_rdata; v.e_req = e_req;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] rsp, input logic [31:0] rd0);
    rst_i       = rst;
    req_i       = req;
    we_i        = we;
    addr_i      = addr;
    wdata_i     = wdata;
    be_i        = addr[3:0] ^ 4'hA;
    rsp_valid_i = rsp;
    rdata_i     = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, rd0};
  endtask

  task automatic check_outs(input string tag, input logic e_stall, input logic e_rv,
                            input logic e_err, input logic [31:0] e_rdata,
                            input logic [3:0] e_req);
    check({tag, ".stall"}, {31'd0, stall_o}, {31'd0, e_stall});
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid_o}, {31'd0, e_rv});
    check({tag, ".err"}, {31'd0, err_o}, {31'd0, e_err});
    check({tag, ".rdata"}, rdata_o, e_rdata);
    check({tag, ".req_o"}, {28'd0, req_o}, {28'd0, e_req});
  endtask

  initial begin
    // rst req we addr wdata rsp rd0 | stall rv err rdata req_o
    vecs[0]  = mk(1,1,0,32'h00000010,0,4'b0000,0,             0,0,0,0,4'b0000);
    vecs[1]  = mk(1,0,0,32'h00000010,0,4'b0000,0,             0,0,0,0,4'b0000);
    vecs[2]  = mk(0,1,0,32'h00000010,0,4'b0000,0,             0,0,0,0,4'b0001);
    vecs[3]  = mk(0,1,0,32'h00000010,0,4'b0000,0,             1,0,0,0,4'b0000);
    vecs[4]  = mk(0,0,0,32'h00000010,0,4'b0001,32'hDEADBEEF,  0,1,0,32'hDEADBEEF,4'b0000);
    vecs[5]  = mk(0,0,0,32'h00000010,0,4'b0001,32'h11111111,  0,0,0,0,4'b0000);
    vecs[6]  = mk(0,1,1,32'h80000803,5,4'b0000,0,             0,0,0,0,4'b0010);
    vecs[7]  = mk(0,0,1,32'h80000803,5,4'b0001,32'h22222222,  0,0,0,0,4'b0000);
    vecs[8]  = mk(0,0,1,32'h80000803,5,4'b0010,0,             0,1,0,0,4'b0000);
    vecs[9]  = mk(0,1,0,32'h00000100,0,4'b0000,0,             0,0,0,0,4'b0000);
    vecs[10] = mk(0,0,0,32'h00000100,0,4'b0000,0,             0,1,1,0,4'b0000);
    vecs[11] = mk(0,1,0,32'h00000010,0,4'b0000,0,             0,0,0,0,4'b0001);
    vecs[12] = mk(0,1,0,32'h80001004,0,4'b0000,0,             1,0,0,0,4'b0000);
    vecs[13] = mk(0,1,0,32'h80001004,0,4'b0001,32'h12345678,  0,1,0,32'h12345678,4'b0100);
    vecs[14] = mk(0,0,0,32'h80001004,0,4'b0100,0,             0,1,0,32'hC2C2C2C2,4'b0000);
    vecs[15] = mk(0,1,0,32'h80003000,0,4'b0000,0,             0,0,0,0,4'b0000);
    vecs[16] = mk(0,1,0,32'h80002010,0,4'b0000,0,             0,1,1,0,4'b1000);
    vecs[17] = mk(0,0,0,32'h80002010,0,4'b1000,0,             0,1,0,32'hD3D3D3D3,4'b0000);
    vecs[18] = mk(0,1,0,32'h00000020,0,4'b0000,0,             0,0,0,0,4'b0001);
    vecs[19] = mk(1,0,0,32'h00000020,0,4'b0000,0,             0,0,0,0,4'b0000);
    vecs[20] = mk(0,0,0,32'h00000020,0,4'b0001,32'h33333333,  0,0,0,0,4'b0000);
    vecs[21] = mk(0,1,0,32'h00000030,0,4'b0000,0,             0,0,0,0,4'b0001);
    vecs[22] = mk(0,0,0,32'h00000030,0,4'b0001,32'hA5A5A5A5,  0,1,0,32'hA5A5A5A5,4'b0000);
    vecs[23] = mk(0,1,0,32'h00000040,0,4'b0000,0,             0,0,0,0,4'b0001);
    vecs[24] = mk(1,0,0,32'h00000040,0,4'b0001,32'h44444444,  0,0,0,0,4'b0000);

    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      drive(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata,
            vecs[i].rsp, vecs[i].rd0);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_rv, vecs[i].e_err,
                 vecs[i].e_rdata, vecs[i].e_req);
      check($sformatf("vec%0d.fwd", i), {we_o, addr_o[30:0]}, {vecs[i].we, vecs[i].addr[30:0]});
      check($sformatf("vec%0d.fwd_wd", i), wdata_o, vecs[i].wdata);
      check($sformatf("vec%0d.fwd_be", i), {28'd0, be_o}, {28'd0, vecs[i].addr[3:0] ^ 4'hA});
    end

    // Leave reset and settle in IDLE.
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 check_outs("idle", 0, 0, 0, 0, 4'b0000);

`ifdef BUS_ROUTER_TIMEOUT_EN
    @(negedge clk_i);
    drive(0, 1, 0, 32'h80002000, 0, 0, 0);
    #1 check_outs("to.acc", 0, 0, 0, 0, 4'b1000);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      drive(0, 0, 0, 32'h80002000, 0, 0, 0);
      #1;
      if (k < 4) check_outs($sformatf("to.wait%0d", k), 0, 0, 0, 0, 4'b0000);
      else       check_outs("to.fire", 0, 1, 1, 0, 4'b0000);
    end
    @(negedge clk_i);
    drive(0, 0, 0, 32'h80002000, 0, 4'b1000, 0);
    #1 check_outs("to.late_idle", 0, 0, 0, 0, 4'b0000);
    @(negedge clk_i);
    drive(0, 1, 0, 32'h00000010, 0, 0, 32'h55555555);
    #1 check_outs("to.acc0", 0, 0, 0, 0, 4'b0001);
    @(negedge clk_i);
    drive(0, 0, 0, 32'h00000010, 0, 4'b1000, 32'h55555555);
    #1 check_outs("to.late_busy", 0, 0, 0, 0, 4'b0000);
    @(negedge clk_i);
    drive(0, 0, 0, 32'h00000010, 0, 4'b0001, 32'h55555555);
    #1 check_outs("to.rsp0", 0, 1, 0, 32'h55555555, 4'b0000);
`else
    @(negedge clk_i);
    drive(0, 1, 0, 32'h80002000, 0, 0, 0);
    #1 check_outs("wait.acc", 0, 0, 0, 0, 4'b1000);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_i);
      drive(0, 1, 0, 32'h00000010, 0, 4'b0111, 0);
      #1;
      check($sformatf("wait%0d.stall", k), {31'd0, stall_o}, 32'd1);
      check($sformatf("wait%0d.rv", k), {31'd0, rsp_valid_o}, 32'd0);
    end
    @(negedge clk_i);
    drive(0, 1, 0, 32'h00000010, 0, 4'b1000, 0);
    #1 check_outs("wait.rsp", 0, 1, 0, 32'hD3D3D3D3, 4'b0001);
`endif

    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
